// File: rtl/SB_codex_pkg.sv
// Shared sideband message definitions.
//
// Provides the message-number enumeration, the decoded sideband message
// type SB_msg_t and reset_SB_msg(), which returns the idle/no-message value
// used wherever a message register is cleared.
package SB_codex_pkg;

    typedef enum logic [4:0] {
        SB_MSG_NONE               = 5'd0,
        MBINIT_PARAM_config_req   = 5'd1,
        MBINIT_PARAM_config_resp  = 5'd2,
        MBINIT_CAL_done_req       = 5'd3,
        MBINIT_CAL_done_resp      = 5'd4,
        MBINIT_REPAIRCLK_init_req = 5'd5,
        MBINIT_REPAIRCLK_init_resp = 5'd6
    } msg_num_t;

    typedef struct packed {
        msg_num_t    msg_id;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_id   = SB_MSG_NONE;
        m.msg_info = 16'h0000;
        return m;
    endfunction

endpackage

// File: rtl/sb_rx_msg_queue.sv
// Sideband receive message queue.
//
// Buffers decoded sideband messages (plus 64-bit payload) from the
// deserializer and hands them to the LTSM one at a time on request.
// A three-state pop FSM (IDLE -> DELIVER -> HOLDOFF) ensures a request held
// for several cycles pops only a single entry.
//
// Ports:
//   clk_100MHz            - sole clock, rising edge
//   reset                 - synchronous, active-high reset
//   flush_i               - discard all queued entries
//   rx_msg_i / rx_data_i  - incoming message and payload
//   rx_msg_valid_i        - one-cycle push strobe
//   SB_RX_msg_req_i       - consumer pop request
//   SB_RX_msg_o           - delivered message (registered, held)
//   SB_RX_dataBus_o       - delivered payload (registered, held)
//   SB_RX_msg_valid_o     - one-cycle strobe qualifying delivered message
//   SB_RX_msg_available_o - queue holds at least one entry
//   count_o               - current occupancy
//   overflow_o            - sticky: a push was dropped on a full queue
module sb_rx_msg_queue
    import SB_codex_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       flush_i,
    input  SB_msg_t                    rx_msg_i,
    input  logic [63:0]                rx_data_i,
    input  logic                       rx_msg_valid_i,
    input  logic                       SB_RX_msg_req_i,
    output SB_msg_t                    SB_RX_msg_o,
    output logic [63:0]                SB_RX_dataBus_o,
    output logic                       SB_RX_msg_valid_o,
    output logic                       SB_RX_msg_available_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StDeliver,
        StHoldoff
    } pop_state_e;

    pop_state_e state_q, state_d;

    SB_msg_t     msg_mem  [DEPTH];
    logic [63:0] data_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    SB_msg_t     msg_q;
    logic [63:0] data_q;
    logic        valid_q;
    logic        available_q;
    logic        overflow_q;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);

        // A flush wins over both sides of the queue in the same cycle.
        pop  = (state_q == StIdle) && SB_RX_msg_req_i && !empty && !flush_i;
        // A pop frees a slot this cycle, so a push on full still fits.
        push = rx_msg_valid_i && (!full || pop) && !flush_i;
        drop = rx_msg_valid_i && full && !pop && !flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pop) state_d = StDeliver;
            StDeliver: state_d = StHoldoff;
            StHoldoff: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            msg_q       <= reset_SB_msg();
            data_q      <= 64'h0;
            valid_q     <= 1'b0;
            available_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= pop;
            available_q <= (count_d != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                msg_q  <= msg_mem[rd_ptr_q];
                data_q <= data_mem[rd_ptr_q];
            end
        end
    end

    // Storage is not reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk_100MHz) begin
        if (!reset && push) begin
            msg_mem[wr_ptr_q]  <= rx_msg_i;
            data_mem[wr_ptr_q] <= rx_data_i;
        end
    end

    assign SB_RX_msg_o           = msg_q;
    assign SB_RX_dataBus_o       = data_q;
    assign SB_RX_msg_valid_o     = valid_q;
    assign SB_RX_msg_available_o = available_q;
    assign count_o               = count_q;
    assign overflow_o            = overflow_q;

endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Directed testbench for sb_rx_msg_queue (DEPTH = 4).
module tb_sb_rx_msg_queue;
    import SB_codex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    SB_msg_t     rx_msg;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        req;
    SB_msg_t     out_msg;
    logic [63:0] out_data;
    logic        out_valid;
    logic        avail;
    logic [2:0]  count;
    logic        overflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sb_rx_msg_queue #(.DEPTH(4)) dut (
        .clk_100MHz            (clk),
        .reset                 (reset),
        .flush_i               (flush),
        .rx_msg_i              (rx_msg),
        .rx_data_i             (rx_data),
        .rx_msg_valid_i        (rx_valid),
        .SB_RX_msg_req_i       (req),
        .SB_RX_msg_o           (out_msg),
        .SB_RX_dataBus_o       (out_data),
        .SB_RX_msg_valid_o     (out_valid),
        .SB_RX_msg_available_o (avail),
        .count_o               (count),
        .overflow_o            (overflow)
    );

    function automatic SB_msg_t mk(input msg_num_t id, input logic [63:0] d);
        SB_msg_t m;
        m.msg_id   = id;
        m.msg_info = d[15:0];
        return m;
    endfunction

    // Inputs change on the falling edge; outputs are observed there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input msg_num_t id, input logic [63:0] d);
        rx_valid = 1'b1;
        rx_msg   = mk(id, d);
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        SB_msg_t zero_msg;
        zero_msg = '0;
        do_reset();
        vectors++; if (count !== 3'd0) begin miscompares++;
            $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (avail !== 1'b0) begin miscompares++;
            $display("FAIL reset_avail: got %b want 0", avail); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (overflow !== 1'b0) begin miscompares++;
            $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++; if (out_msg !== zero_msg) begin miscompares++;
            $display("FAIL reset_msg: got %h want %h", out_msg, zero_msg); end
        vectors++; if (out_data !== 64'h0) begin miscompares++;
            $display("FAIL reset_data: got %h want 0", out_data); end
    endtask

    task automatic test_basic();
        msg_num_t ids [3];
        ids[0] = MBINIT_PARAM_config_req;
        ids[1] = MBINIT_PARAM_config_resp;
        ids[2] = MBINIT_CAL_done_req;
        for (int i = 0; i < 3; i++) push(ids[i], 64'(i + 1));
        vectors++; if (count !== 3'd3) begin miscompares++;
            $display("FAIL basic_count: got %0d want 3", count); end
        vectors++; if (avail !== 1'b1) begin miscompares++;
            $display("FAIL basic_avail: got %b want 1", avail); end
        for (int i = 0; i < 3; i++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            vectors++; if (out_valid !== 1'b1) begin miscompares++;
                $display("FAIL basic_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++; if (out_msg !== mk(ids[i], 64'(i + 1))) begin miscompares++;
                $display("FAIL basic_msg[%0d]: got %h want %h", i, out_msg,
                         mk(ids[i], 64'(i + 1))); end
            vectors++; if (out_data !== 64'(i + 1)) begin miscompares++;
                $display("FAIL basic_data[%0d]: got %h want %0d", i, out_data, i + 1); end
            vectors++; if (count !== 3'(2 - i)) begin miscompares++;
                $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, count, 2 - i); end
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++;
                $display("FAIL basic_strobe_len[%0d]: got %b want 0", i, out_valid); end
            vectors++; if (out_data !== 64'(i + 1)) begin miscompares++;
                $display("FAIL basic_hold[%0d]: got %h want %0d", i, out_data, i + 1); end
            tick();
        end
        vectors++; if (avail !== 1'b0) begin miscompares++;
            $display("FAIL basic_avail_end: got %b want 0", avail); end
    endtask

    task automatic test_no_bypass_hold();
        // Push and request together on an empty queue: no bypass.
        rx_valid = 1'b1;
        rx_msg   = mk(MBINIT_CAL_done_resp, 64'h42);
        rx_data  = 64'hA5A5_0000_0000_0042;
        req      = 1'b1;
        tick();
        rx_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++;
            $display("FAIL nobypass_valid: got %b want 0", out_valid); end
        vectors++; if (avail !== 1'b1 || count !== 3'd1) begin miscompares++;
            $display("FAIL nobypass_avail: got avail %b cnt %0d want 1/1", avail, count); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 64'hA5A5_0000_0000_0042) begin
            miscompares++;
            $display("FAIL hold_pop: got valid %b data %h want 1/a5a5000000000042",
                     out_valid, out_data); end
        vectors++; if (count !== 3'd0) begin miscompares++;
            $display("FAIL hold_count: got %0d want 0", count); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req = 1'b0;
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++;
                $display("FAIL hold_extra_valid[%0d]: got %b want 0", i, out_valid); end
        end
        // Request on an empty queue is ignored.
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        vectors++; if (out_valid !== 1'b0 || count !== 3'd0) begin miscompares++;
            $display("FAIL empty_req: got valid %b cnt %0d want 0/0", out_valid, count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(MBINIT_PARAM_config_req, 64'h100 + 64'(i));
            if (i == 3) begin
                vectors++; if (count !== 3'd4 || overflow !== 1'b0) begin miscompares++;
                    $display("FAIL ovf_full: got cnt %0d ovf %b want 4/0", count, overflow); end
            end
        end
        vectors++; if (count !== 3'd4 || overflow !== 1'b1) begin miscompares++;
            $display("FAIL ovf_set: got cnt %0d ovf %b want 4/1", count, overflow); end
        for (int i = 0; i < 4; i++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            vectors++; if (out_valid !== 1'b1 || out_data !== 64'h100 + 64'(i)) begin
                miscompares++;
                $display("FAIL ovf_pop[%0d]: got valid %b data %h want 1/%h", i, out_valid,
                         out_data, 64'h100 + 64'(i)); end
            tick();
            tick();
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        vectors++; if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drained: got valid %b cnt %0d ovf %b want 0/0/1",
                     out_valid, count, overflow); end
        tick();
    endtask

    task automatic test_flush();
        push(MBINIT_CAL_done_req, 64'h200);
        push(MBINIT_CAL_done_req, 64'h201);
        req = 1'b1;
        tick();
        req = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== 64'h200 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_deliver: got valid %b data %h cnt %0d want 1/200/1",
                     out_valid, out_data, count); end
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_msg   = mk(MBINIT_CAL_done_req, 64'h2FF);
        rx_data  = 64'h2FF;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        vectors++; if (count !== 3'd0 || avail !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got cnt %0d avail %b valid %b want 0/0/0",
                     count, avail, out_valid); end
        vectors++; if (overflow !== 1'b1) begin miscompares++;
            $display("FAIL flush_ovf: got %b want 1", overflow); end
        req = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++;
            $display("FAIL flush_req1: got %b want 0", out_valid); end
        tick();
        req = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++;
            $display("FAIL flush_req2: got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push(MBINIT_PARAM_config_resp, 64'h10 + 64'(i));
        for (int k = 0; k < 4; k++) begin
            rx_valid = 1'b1;
            rx_msg   = mk(MBINIT_PARAM_config_resp, 64'h14 + 64'(k));
            rx_data  = 64'h14 + 64'(k);
            req      = 1'b1;
            tick();
            rx_valid = 1'b0;
            req      = 1'b0;
            vectors++; if (out_valid !== 1'b1 || out_data !== 64'h10 + 64'(k)) begin
                miscompares++;
                $display("FAIL pp_pop[%0d]: got valid %b data %h want 1/%h", k, out_valid,
                         out_data, 64'h10 + 64'(k)); end
            vectors++; if (count !== 3'd4 || overflow !== 1'b0) begin miscompares++;
                $display("FAIL pp_count[%0d]: got cnt %0d ovf %b want 4/0", k, count,
                         overflow); end
            tick();
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            vectors++; if (out_msg !== mk(MBINIT_PARAM_config_resp, 64'h14 + 64'(k)) ||
                           out_data !== 64'h14 + 64'(k)) begin
                miscompares++;
                $display("FAIL wrap_pop[%0d]: got msg %h data %h want data %h", k, out_msg,
                         out_data, 64'h14 + 64'(k)); end
            vectors++; if (count !== 3'(3 - k)) begin miscompares++;
                $display("FAIL wrap_count[%0d]: got %0d want %0d", k, count, 3 - k); end
            tick();
            tick();
        end
    endtask

    task automatic test_reset_mid_deliver();
        SB_msg_t zero_msg;
        zero_msg = '0;
        do_reset();
        for (int i = 0; i < 5; i++) push(MBINIT_CAL_done_resp, 64'h40 + 64'(i));
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        vectors++; if (out_valid !== 1'b1 || count !== 3'd2 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: got valid %b cnt %0d ovf %b want 1/2/1",
                     out_valid, count, overflow); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (out_valid !== 1'b0 || count !== 3'd0 || avail !== 1'b0 ||
                       overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got valid %b cnt %0d avail %b ovf %b want 0/0/0/0",
                     out_valid, count, avail, overflow); end
        vectors++; if (out_msg !== zero_msg || out_data !== 64'h0) begin miscompares++;
            $display("FAIL rst_mid_out: got msg %h data %h want 0/0", out_msg, out_data); end
        req = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_req: got %b want 0", out_valid); end
        tick();
        req = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        rx_msg   = '0;
        rx_data  = 64'h0;
        rx_valid = 1'b0;
        req      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_no_bypass_hold();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_reset_mid_deliver();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
